// File: rtl/uart_serialize_if.sv
// Byte handshake bundle between the packet source and the UART transmit serializer.
// Latency: none, wires only.
// Backpressure: a byte moves on an edge where tx_valid && tx_ready.
// Ports: tx_data (byte), tx_valid (source has a byte), tx_ready (serializer FIFO has room).
// master = packet source side, slave = serializer side.
interface uart_serialize_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_serialize.sv
// UART transmit serializer: byte FIFO feeding a frame shifter (start 1, 8 data LSB first, even-XOR parity, stop 0).
// Latency: a byte pushed into an empty FIFO while idle drives its start bit one clk_baud edge later.
// Backpressure: tx_ready drops while the FIFO holds DEPTH bytes; frames are contiguous while the FIFO is non-empty.
// Ports: clk_baud (bit clock), rst (sync, active high), tx (uart_serialize_if.slave byte handshake),
//        uart_stream (registered serial line, idles at 0), busy (a frame bit is on the line),
//        fifo_count (bytes queued).
// Optional macro UART_TX_PARITY_ERR_INJECT_EN: adds err_inject; when high on the pop edge the
// frame's parity bit is inverted.
module uart_serialize #(
    parameter int DEPTH    = 4,
    parameter int GAP_BITS = 0
) (
    input  logic                   clk_baud,
    input  logic                   rst,
`ifdef UART_TX_PARITY_ERR_INJECT_EN
    input  logic                   err_inject,
`endif
    uart_serialize_if.slave        tx,
    output logic                   uart_stream,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // START has no cycle of its own: the start bit is driven on the IDLE->DATA edge.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic          inj;

    state_t        state;
    logic [7:0]    shift;
    logic          par;
    logic [2:0]    bit_idx;
    logic [3:0]    gap_cnt;

`ifdef UART_TX_PARITY_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    // Ready depends on the stored count only, so a pop on the same edge
    // never opens a full FIFO; it is also held low throughout reset.
    assign tx.tx_ready = !rst && (count != CW'(DEPTH));
    assign push        = tx.tx_valid && tx.tx_ready;
    assign pop         = (state == IDLE) && (count != '0);
    assign head        = mem[rd_ptr];
    assign fifo_count  = count;

    always_ff @(posedge clk_baud) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap by overflow.
    always_ff @(posedge clk_baud) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // busy mirrors "a frame bit was driven at this edge", so it stays high
    // through the stop bit and every gap bit.
    always_ff @(posedge clk_baud) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            par         <= 1'b0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            uart_stream <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_stream <= 1'b0;
                    busy        <= 1'b0;
                    if (pop) begin
                        shift       <= head;
                        par         <= (^head) ^ inj;
                        bit_idx     <= '0;
                        uart_stream <= 1'b1;
                        busy        <= 1'b1;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    uart_stream <= shift[bit_idx];
                    busy        <= 1'b1;
                    bit_idx     <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    uart_stream <= par;
                    busy        <= 1'b1;
                    state       <= STOP;
                end
                STOP: begin
                    uart_stream <= 1'b0;
                    busy        <= 1'b1;
                    gap_cnt     <= '0;
                    if (GAP_BITS > 0) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    // One edge per gap bit; the last one hands back to IDLE so the
                    // next start lands GAP_BITS edges after the stop bit.
                    uart_stream <= 1'b0;
                    busy        <= 1'b1;
                    gap_cnt     <= gap_cnt + 1'b1;
                    if (gap_cnt == 4'(GAP_BITS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_stream <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
